// File: rtl/deemph_iir.sv
// First-order de-emphasis IIR: y[n] = DQ(CX0*x[n]) + DQ(CX1*x[n-1]) + DQ(CY1*y[n-1]).
// One time-shared multiplier, FIFO in / FIFO out, five-cycle minimum sample period.
module deemph_iir #(
  parameter int                            DATA_SIZE = 32,
  parameter logic signed [DATA_SIZE-1:0]   CX0       = 178,
  parameter logic signed [DATA_SIZE-1:0]   CX1       = 178,
  parameter logic signed [DATA_SIZE-1:0]   CY1       = -666
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_SIZE-1:0]  i_in,
  output logic                  o_in_rd_en,
  input  logic                  i_in_empty,
  output logic [DATA_SIZE-1:0]  o_out,
  output logic                  o_out_wr_en,
  input  logic                  i_out_full
);

  localparam int PW = 2 * DATA_SIZE;

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t                      r_state, w_state_next;
  logic [1:0]                  r_tap, w_tap_next;
  logic signed [DATA_SIZE-1:0] r_x0, r_x1, r_y1, r_acc;
  logic signed [DATA_SIZE-1:0] w_x0_next, w_x1_next, w_y1_next, w_acc_next;
  logic signed [DATA_SIZE-1:0] w_coef, w_opnd, w_dq;
  logic signed [PW-1:0]        w_coef_ext, w_opnd_ext, w_prod, w_mag, w_quot;
  logic                        w_rd, w_wr;

  always_comb begin
    w_coef = CX0;
    w_opnd = r_x0;
    case (r_tap)
      2'd1:    begin w_coef = CX1; w_opnd = r_x1; end
      2'd2:    begin w_coef = CY1; w_opnd = r_y1; end
      default: begin w_coef = CX0; w_opnd = r_x0; end
    endcase
  end

  assign w_coef_ext = {{DATA_SIZE{w_coef[DATA_SIZE-1]}}, w_coef};
  assign w_opnd_ext = {{DATA_SIZE{w_opnd[DATA_SIZE-1]}}, w_opnd};
  assign w_prod     = w_coef_ext * w_opnd_ext;

  // Divide by 1024 rounding toward zero: shift the magnitude, then restore the sign.
  assign w_mag  = w_prod[PW-1] ? -w_prod : w_prod;
  assign w_quot = w_mag >>> 10;
  assign w_dq   = DATA_SIZE'(w_prod[PW-1] ? -w_quot : w_quot);

  always_comb begin
    w_state_next = r_state;
    w_tap_next   = r_tap;
    w_acc_next   = r_acc;
    w_x0_next    = r_x0;
    w_x1_next    = r_x1;
    w_y1_next    = r_y1;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_in_empty && i_rst_n) begin
          w_rd         = 1'b1;
          w_x1_next    = r_x0;
          w_x0_next    = i_in;
          w_acc_next   = '0;
          w_tap_next   = 2'd0;
          w_state_next = MAC;
        end
      end
      MAC: begin
        if (r_tap == 2'd3) begin
          w_state_next = IDLE;
        end else begin
          w_acc_next = r_acc + w_dq;
          w_tap_next = r_tap + 2'd1;
          if (r_tap == 2'd2) w_state_next = WRITE;
        end
      end
      WRITE: begin
        if (!i_out_full) begin
          w_wr         = 1'b1;
          w_y1_next    = r_acc;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_tap   <= '0;
      r_acc   <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else begin
      r_state <= w_state_next;
      r_tap   <= w_tap_next;
      r_acc   <= w_acc_next;
      r_x0    <= w_x0_next;
      r_x1    <= w_x1_next;
      r_y1    <= w_y1_next;
    end
  end

  assign o_in_rd_en  = w_rd;
  assign o_out_wr_en = w_wr;
  assign o_out       = w_wr ? r_acc : '0;

endmodule

// File: tb/tb_deemph_iir.sv
// Directed bench for deemph_iir: impulse, latency, back-pressure, rounding,
// mid-computation reset and a randomised stream against a reference model.
module tb_deemph_iir;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_rd_en;
  logic        in_empty;
  logic [31:0] out_data;
  logic        out_wr_en;
  logic        out_full;

  int n_vec = 0;
  int n_err = 0;
  logic signed [31:0] m_x0 = 0, m_x1 = 0, m_y1 = 0;

  deemph_iir dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in        (in_data),
    .o_in_rd_en  (in_rd_en),
    .i_in_empty  (in_empty),
    .o_out       (out_data),
    .o_out_wr_en (out_wr_en),
    .i_out_full  (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample, expect a one-cycle pop, three silent MAC cycles,
  // full_cyc stalled WRITE cycles, then the push carrying exp.
  task automatic send(input logic signed [31:0] x, input int full_cyc,
                      input bit hold_nonempty, input logic signed [31:0] exp,
                      input string tag);
    in_data  = x;
    in_empty = 1'b0;
    #1;
    check({tag, "/rd"}, {31'd0, in_rd_en}, 1);
    check({tag, "/wr_idle"}, {31'd0, out_wr_en}, 0);
    tick();
    in_empty = hold_nonempty ? 1'b0 : 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check({tag, "/mac_quiet"}, {30'd0, in_rd_en, out_wr_en}, 0);
      tick();
    end
    for (int k = 0; k < full_cyc; k++) begin
      out_full = 1'b1;
      #1;
      check({tag, "/stall_quiet"}, {30'd0, in_rd_en, out_wr_en}, 0);
      tick();
    end
    out_full = 1'b0;
    #1;
    check({tag, "/wr"}, {31'd0, out_wr_en}, 1);
    check({tag, "/rd_in_wr"}, {31'd0, in_rd_en}, 0);
    check({tag, "/out"}, out_data, exp);
    $display("%s: in=%0d out=%0d expected=%0d", tag, x, $signed(out_data), exp);
    tick();
    in_empty = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst/out", out_data, 0);
    check("rst/wr", {31'd0, out_wr_en}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    m_x0 = 0; m_x1 = 0; m_y1 = 0;
  endtask

  function automatic logic signed [31:0] dq(input longint p);
    longint q;
    if (p < 0) q = -((-p) >>> 10);
    else       q = p >>> 10;
    return q[31:0];
  endfunction

  function automatic logic signed [31:0] model(input logic signed [31:0] x);
    logic signed [31:0] y;
    m_x1 = m_x0;
    m_x0 = x;
    y = dq(longint'(178) * longint'(m_x0)) + dq(longint'(178) * longint'(m_x1))
      + dq(longint'(-666) * longint'(m_y1));
    m_y1 = y;
    return y;
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_empty = 1'b1;
    out_full = 1'b0;
    #1;
    in_empty = 1'b0;
    #1;
    check("reset/rd", {31'd0, in_rd_en}, 0);
    check("reset/wr", {31'd0, out_wr_en}, 0);
    check("reset/out", out_data, 0);
    in_empty = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Impulse response with idle gaps between samples
    send(1024, 0, 1'b0, 178, "imp0");
    tick();
    send(1024, 0, 1'b0, 241, "imp1");
    tick(); tick();
    send(0, 0, 1'b0, 22, "imp2");

    // Latency from clean history
    do_reset();
    send(2048, 0, 1'b0, 356, "lat");

    // Back-pressure with a non-empty input FIFO during the stall
    do_reset();
    send(2048, 6, 1'b1, 356, "bp");

    // Rounding toward zero on negative products
    do_reset();
    send(-1, 0, 1'b0, 0, "neg1");
    send(-1024, 0, 1'b0, -178, "neg1024");

    // Reset asserted two cycles after the read
    do_reset();
    in_data  = 1024;
    in_empty = 1'b0;
    #1;
    check("abort/rd", {31'd0, in_rd_en}, 1);
    tick();
    in_empty = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort/wr_in_rst", {31'd0, out_wr_en}, 0);
    check("abort/out_in_rst", out_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("abort/no_write", {31'd0, out_wr_en}, 0);
      tick();
    end
    send(1024, 0, 1'b0, 178, "abort/next");

    // Random stream against the reference model
    do_reset();
    for (int i = 0; i < 64; i++) begin
      logic signed [31:0] x;
      logic signed [31:0] e;
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        in_empty = 1'b1;
        #1;
        check("rand/idle_rd", {31'd0, in_rd_en}, 0);
        tick();
      end
      x = int'($urandom_range(0, 65535)) - 32768;
      e = model(x);
      send(x, int'($urandom_range(0, 3)), 1'b0, e, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
